// File: rtl/remote_player_ctrl.sv
// Remote player link: parses the 7-byte UART state packet, validates its XOR checksum,
// and commits position/level to the draw stage only at the start of vertical blanking.
module remote_player_ctrl #(
   parameter int unsigned BYTE_TIMEOUT        = 100000,
   parameter int unsigned LINK_TIMEOUT_FRAMES = 60,
   parameter int unsigned X_MAX               = 977,
   parameter int unsigned Y_MAX               = 705
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [7:0]  rx_data,
   input  logic        rx_valid,
   input  logic        vblnk,
   output logic [11:0] x_value,
   output logic [11:0] y_value,
   output logic [1:0]  level_remote,
   output logic        remote_active,
   output logic [7:0]  pkt_err_cnt
);

   localparam int unsigned       TMR_W    = $clog2(BYTE_TIMEOUT + 1);
   localparam int unsigned       MISS_W   = $clog2(LINK_TIMEOUT_FRAMES + 1);
   localparam logic [7:0]        HDR      = 8'hA5;
   localparam logic [11:0]       X_LIM    = 12'(X_MAX);
   localparam logic [11:0]       Y_LIM    = 12'(Y_MAX);
   localparam logic [TMR_W-1:0]  TMR_LAST = TMR_W'(BYTE_TIMEOUT - 1);
   localparam logic [MISS_W-1:0] MISS_MAX = MISS_W'(LINK_TIMEOUT_FRAMES);

   typedef enum logic [2:0] {IDLE, X_HI, X_LO, Y_HI, Y_LO, LVL, CHK} state_t;

   function automatic logic [11:0] clamp_pos(input logic [11:0] v, input logic [11:0] lim);
      return (v > lim) ? lim : v;
   endfunction

   function automatic logic [7:0] sat_inc_err(input logic [7:0] v);
      return (v == 8'hFF) ? v : v + 8'd1;
   endfunction

   function automatic logic [MISS_W-1:0] sat_inc_miss(input logic [MISS_W-1:0] v);
      return (v >= MISS_MAX) ? MISS_MAX : v + MISS_W'(1);
   endfunction

   state_t            state, state_n;
   logic [TMR_W-1:0]  tmr;
   logic              tmr_expired, pkt_good, pkt_bad;
   logic [3:0]        x_hi, y_hi;
   logic [7:0]        x_lo, y_lo, chk_acc;
   logic [1:0]        lvl;
   logic [11:0]       sh_x, sh_y;
   logic [1:0]        sh_lvl;
   logic              pending;
   logic              vblnk_r, vblnk_prev, vblnk_rise, commit;
   logic [MISS_W-1:0] miss;

   assign tmr_expired = (state != IDLE) && (tmr == TMR_LAST);
   assign vblnk_rise  = vblnk_r & ~vblnk_prev;
   assign commit      = vblnk_rise & pending;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) state <= IDLE;
      else      state <= state_n;
   end

   // A received byte always wins over a timeout expiring on the same cycle.
   always_comb begin
      state_n  = state;
      pkt_good = 1'b0;
      pkt_bad  = 1'b0;
      if (rx_valid) begin
         case (state)
            IDLE: if (rx_data == HDR) state_n = X_HI;
            X_HI: state_n = X_LO;
            X_LO: state_n = Y_HI;
            Y_HI: state_n = Y_LO;
            Y_LO: state_n = LVL;
            LVL:  state_n = CHK;
            CHK: begin
               state_n = IDLE;
               if (rx_data == chk_acc) pkt_good = 1'b1;
               else                    pkt_bad  = 1'b1;
            end
            default: state_n = IDLE;
         endcase
      end else if (tmr_expired) begin
         state_n = IDLE;
         pkt_bad = 1'b1;
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         tmr     <= '0;
         x_hi    <= '0;
         x_lo    <= '0;
         y_hi    <= '0;
         y_lo    <= '0;
         lvl     <= '0;
         chk_acc <= '0;
      end else begin
         if (rx_valid || state == IDLE || tmr_expired) tmr <= '0;
         else                                          tmr <= tmr + TMR_W'(1);
         if (rx_valid) begin
            case (state)
               X_HI: begin x_hi <= rx_data[3:0]; chk_acc <= rx_data; end
               X_LO: begin x_lo <= rx_data;      chk_acc <= chk_acc ^ rx_data; end
               Y_HI: begin y_hi <= rx_data[3:0]; chk_acc <= chk_acc ^ rx_data; end
               Y_LO: begin y_lo <= rx_data;      chk_acc <= chk_acc ^ rx_data; end
               LVL:  begin lvl  <= rx_data[1:0]; chk_acc <= chk_acc ^ rx_data; end
               default: ;
            endcase
         end
      end
   end

   // Shadows load on a good packet; a commit on the same edge still takes the old shadow.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         sh_x        <= '0;
         sh_y        <= '0;
         sh_lvl      <= '0;
         pending     <= 1'b0;
         pkt_err_cnt <= '0;
      end else begin
         if (pkt_good) begin
            sh_x    <= clamp_pos({x_hi, x_lo}, X_LIM);
            sh_y    <= clamp_pos({y_hi, y_lo}, Y_LIM);
            sh_lvl  <= lvl;
            pending <= 1'b1;
         end else if (commit) begin
            pending <= 1'b0;
         end
         if (pkt_bad) pkt_err_cnt <= sat_inc_err(pkt_err_cnt);
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         vblnk_r       <= 1'b0;
         vblnk_prev    <= 1'b0;
         x_value       <= '0;
         y_value       <= '0;
         level_remote  <= '0;
         remote_active <= 1'b0;
         miss          <= '0;
      end else begin
         vblnk_r    <= vblnk;
         vblnk_prev <= vblnk_r;
         if (commit) begin
            x_value       <= sh_x;
            y_value       <= sh_y;
            level_remote  <= sh_lvl;
            remote_active <= 1'b1;
            miss          <= '0;
         end else if (vblnk_rise) begin
            miss <= sat_inc_miss(miss);
            if (sat_inc_miss(miss) >= MISS_MAX) remote_active <= 1'b0;
         end
      end
   end

endmodule
